// File: rtl/rgbd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// rgbd_frame_sequencer
//
// Frame source and pose bookkeeper for the RGB-D visual-odometry top.
// It reads stored gray/depth frames through two read ports with 1-cycle
// latency and streams them into the VO core.
//
// Feature phase: frames 0..N_FEATURE-1 are streamed one at a time on
// port 0. After each frame the block waits for i_feature_ready. After the
// last frame it waits for the core's first pose solve.
//
// Direct phase: port 1 streams frame 1 at once. Port 0 streams frame 0,
// starting S0_DELAY cycles after port 1. Each returned pose/sigma set is
// latched, and the dual stream is repeated N_DIRECT times.
//
// Optional build macro: RGBD_SEQ_STALL_EN adds input i_stall. While it is
// high, no new read strobes are issued and the port-0 delay counter holds.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_go / o_busy / o_all_done    run start, busy flag, end-of-run pulse
//   o_rdN_en/_frame/_addr         read strobe, frame index, pixel address
//   i_rdN_pixel/_depth            read data, valid 1 cycle after the strobe
//   o_frame_start, o_f_or_d       first-beat marker, phase (0 feat, 1 dir)
//   o_valid_N, o_dataN, o_depthN  stream N to the core
//   i_feature_ready, i_done       core handshakes
//   i_pose, i_sigma_*_next        new pose and sigmas from the core
//   o_pose, o_sigma_*             current pose and sigmas to the core
//   o_err_done                    sticky: i_done seen outside a wait state
// ---------------------------------------------------------------------------
module rgbd_frame_sequencer #(
    parameter int          H_SIZE          = 640,
    parameter int          V_SIZE          = 480,
    parameter int          N_FEATURE       = 3,
    parameter int          N_DIRECT        = 3,
    parameter int          S0_DELAY        = 19840,
    parameter int          POSE_BW         = 42,
    parameter logic [83:0] SIGMA_ICP_INIT  = 84'd8248117036366702,
    parameter logic [8:0]  SIGMA_RGBD_INIT = 9'd5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_go,
`ifdef RGBD_SEQ_STALL_EN
    input  logic                       i_stall,
`endif
    output logic                       o_busy,
    output logic                       o_all_done,
    output logic                       o_rd0_en,
    output logic [1:0]                 o_rd0_frame,
    output logic [18:0]                o_rd0_addr,
    input  logic [7:0]                 i_rd0_pixel,
    input  logic [15:0]                i_rd0_depth,
    output logic                       o_rd1_en,
    output logic [1:0]                 o_rd1_frame,
    output logic [18:0]                o_rd1_addr,
    input  logic [7:0]                 i_rd1_pixel,
    input  logic [15:0]                i_rd1_depth,
    output logic                       o_frame_start,
    output logic                       o_f_or_d,
    output logic                       o_valid_0,
    output logic [7:0]                 o_data0,
    output logic [15:0]                o_depth0,
    output logic                       o_valid_1,
    output logic [7:0]                 o_data1,
    output logic [15:0]                o_depth1,
    input  logic                       i_feature_ready,
    input  logic                       i_done,
    input  logic [11:0][POSE_BW-1:0]   i_pose,
    input  logic [83:0]                i_sigma_icp_next,
    input  logic [8:0]                 i_sigma_rgbd_next,
    output logic [11:0][POSE_BW-1:0]   o_pose,
    output logic [83:0]                o_sigma_icp,
    output logic [8:0]                 o_sigma_rgbd,
    output logic                       o_err_done
);

    localparam int                  NPIX     = H_SIZE * V_SIZE;
    localparam logic [18:0]         LAST     = 19'(NPIX - 1);
    localparam int                  DLY_W    = $clog2(S0_DELAY + 2);
    localparam logic [DLY_W-1:0]    DLY_MAX  = DLY_W'(S0_DELAY);
    localparam logic [POSE_BW-1:0]  ONE_Q24  = POSE_BW'(64'd16777216);

    typedef enum logic [2:0] {
        IDLE, FEAT_STR, FEAT_WAIT, DONE_WAIT, DIR_STR, DIR_WAIT, FINISH
    } state_t;

    state_t            state;
    logic [1:0]        cnt_f;
    logic [7:0]        cnt_d;
    logic [18:0]       nxt0, nxt1;      // next address each port will strobe
    logic              done0, done1;    // port has strobed its last pixel
    logic [DLY_W-1:0]  dcnt;            // unstalled direct-phase edges so far

    logic              stall;
`ifdef RGBD_SEQ_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    // Read data arrives 1 cycle after the strobe, the same cycle the
    // registered valid is high, so data is passed through and gated by valid.
    assign o_data0  = o_valid_0 ? i_rd0_pixel : '0;
    assign o_depth0 = o_valid_0 ? i_rd0_depth : '0;
    assign o_data1  = o_valid_1 ? i_rd1_pixel : '0;
    assign o_depth1 = o_valid_1 ? i_rd1_depth : '0;

    // A stream (re)starts on the same edge that enters its streaming state,
    // so the first strobe is visible in the first cycle of that state.
    logic              go_feat, go_dir, dir_act, issue0, issue1;
    logic [18:0]       base0_nxt, base1_nxt;
    logic              base0_done, base1_done;
    logic [DLY_W-1:0]  base_dcnt;

    // NOTE: every always_comb output gets a value on every path; a missing
    // assignment would infer a latch.
    always_comb begin
        go_feat    = (state == IDLE && i_go) || (state == FEAT_WAIT && i_feature_ready);
        go_dir     = i_done && (state == DONE_WAIT ||
                     (state == DIR_WAIT && (cnt_d + 8'd1) < 8'(N_DIRECT)));
        dir_act    = go_dir || state == DIR_STR;
        base0_nxt  = (go_feat || go_dir) ? '0 : nxt0;
        base0_done = (go_feat || go_dir) ? 1'b0 : done0;
        base1_nxt  = go_dir ? '0 : nxt1;
        base1_done = go_dir ? 1'b0 : done1;
        base_dcnt  = go_dir ? '0 : dcnt;
        issue0     = !stall && !base0_done &&
                     (go_feat || state == FEAT_STR || (dir_act && base_dcnt >= DLY_MAX));
        issue1     = !stall && !base1_done && dir_act;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt_f         <= '0;
            cnt_d         <= '0;
            nxt0          <= '0;
            nxt1          <= '0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            dcnt          <= '0;
            o_busy        <= 1'b0;
            o_all_done    <= 1'b0;
            o_err_done    <= 1'b0;
            o_f_or_d      <= 1'b0;
            o_frame_start <= 1'b0;
            o_rd0_en      <= 1'b0;
            o_rd0_frame   <= '0;
            o_rd0_addr    <= '0;
            o_rd1_en      <= 1'b0;
            o_rd1_frame   <= '0;
            o_rd1_addr    <= '0;
            o_valid_0     <= 1'b0;
            o_valid_1     <= 1'b0;
            for (int k = 0; k < 12; k++)
                o_pose[k] <= (k == 0 || k == 5 || k == 10) ? ONE_Q24 : '0;
            o_sigma_icp   <= SIGMA_ICP_INIT;
            o_sigma_rgbd  <= SIGMA_RGBD_INIT;
        end else begin
            // Port 0 strobe generator; the address saturates at the last pixel.
            o_rd0_en <= issue0;
            if (issue0) begin
                o_rd0_addr <= base0_nxt;
                nxt0       <= (base0_nxt == LAST) ? base0_nxt : base0_nxt + 19'd1;
                done0      <= (base0_nxt == LAST);
            end else begin
                nxt0       <= base0_nxt;
                done0      <= base0_done;
            end

            // Port 1 strobe generator.
            o_rd1_en <= issue1;
            if (issue1) begin
                o_rd1_addr <= base1_nxt;
                nxt1       <= (base1_nxt == LAST) ? base1_nxt : base1_nxt + 19'd1;
                done1      <= (base1_nxt == LAST);
            end else begin
                nxt1       <= base1_nxt;
                done1      <= base1_done;
            end

            // Port-0 start delay: saturating, holds while stalled.
            if (dir_act && !stall && base_dcnt < DLY_MAX)
                dcnt <= base_dcnt + DLY_W'(1);
            else
                dcnt <= base_dcnt;

            o_valid_0     <= o_rd0_en;
            o_valid_1     <= o_rd1_en;
            // Frame start marks the addr-0 beat of stream 0 (feature) or 1 (direct).
            o_frame_start <= o_f_or_d ? (o_rd1_en && o_rd1_addr == '0)
                                      : (o_rd0_en && o_rd0_addr == '0);

            if (i_done && !(state == DONE_WAIT || state == DIR_WAIT))
                o_err_done <= 1'b1;

            o_all_done <= 1'b0;

            case (state)
                IDLE: if (i_go) begin
                    state       <= FEAT_STR;
                    cnt_f       <= '0;
                    o_rd0_frame <= '0;
                    o_busy      <= 1'b1;
                end
                FEAT_STR: if (done0)
                    state <= (cnt_f == 2'(N_FEATURE - 1)) ? DONE_WAIT : FEAT_WAIT;
                FEAT_WAIT: if (i_feature_ready) begin
                    cnt_f       <= cnt_f + 2'd1;
                    o_rd0_frame <= cnt_f + 2'd1;
                    state       <= FEAT_STR;
                end
                DONE_WAIT: if (i_done) begin
                    // The first solve only updates the pose; sigmas are kept.
                    o_pose      <= i_pose;
                    o_f_or_d    <= 1'b1;
                    cnt_d       <= '0;
                    o_rd0_frame <= 2'd0;
                    o_rd1_frame <= 2'd1;
                    state       <= DIR_STR;
                end
                DIR_STR: if (done0 && done1)
                    state <= DIR_WAIT;
                DIR_WAIT: if (i_done) begin
                    o_pose       <= i_pose;
                    o_sigma_icp  <= i_sigma_icp_next;
                    o_sigma_rgbd <= i_sigma_rgbd_next;
                    cnt_d        <= cnt_d + 8'd1;
                    if ((cnt_d + 8'd1) < 8'(N_DIRECT)) begin
                        state <= DIR_STR;
                    end else begin
                        state      <= FINISH;
                        o_all_done <= 1'b1;
                    end
                end
                FINISH: begin
                    o_f_or_d <= 1'b0;
                    o_busy   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgbd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgbd_frame_sequencer
//
// Small configuration (8x4 frames, 2 feature frames, 2 direct iterations,
// port-0 delay 5). A memory model answers both read ports one cycle after
// each strobe. The stimulus thread pushes the expected beats of every frame
// into per-stream queues; a negedge monitor pops and compares each valid
// beat. Timing, pose/sigma bookkeeping and error flag are checked inline.
// ---------------------------------------------------------------------------
module tb_rgbd_frame_sequencer;

    localparam int          H = 8, V = 4, NPIX = H * V;
    localparam int          PBW = 42;
    localparam logic [83:0] ICP_INIT = 84'd8248117036366702;
    localparam logic [8:0]  RGBD_INIT = 9'd5;
    localparam logic [PBW-1:0] ONE = 42'd16777216;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_go, i_feature_ready, i_done;
    logic                  o_busy, o_all_done, o_frame_start, o_f_or_d, o_err_done;
    logic                  o_rd0_en, o_rd1_en;
    logic [1:0]            o_rd0_frame, o_rd1_frame;
    logic [18:0]           o_rd0_addr, o_rd1_addr;
    logic [7:0]            i_rd0_pixel, i_rd1_pixel, o_data0, o_data1;
    logic [15:0]           i_rd0_depth, i_rd1_depth, o_depth0, o_depth1;
    logic                  o_valid_0, o_valid_1;
    logic [11:0][PBW-1:0]  i_pose, o_pose;
    logic [83:0]           i_sigma_icp_next, o_sigma_icp;
    logic [8:0]            i_sigma_rgbd_next, o_sigma_rgbd;
`ifdef RGBD_SEQ_STALL_EN
    logic                  i_stall = 1'b0;
`endif

    rgbd_frame_sequencer #(
        .H_SIZE(H), .V_SIZE(V), .N_FEATURE(2), .N_DIRECT(2), .S0_DELAY(5), .POSE_BW(PBW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go),
`ifdef RGBD_SEQ_STALL_EN
        .i_stall(i_stall),
`endif
        .o_busy(o_busy), .o_all_done(o_all_done),
        .o_rd0_en(o_rd0_en), .o_rd0_frame(o_rd0_frame), .o_rd0_addr(o_rd0_addr),
        .i_rd0_pixel(i_rd0_pixel), .i_rd0_depth(i_rd0_depth),
        .o_rd1_en(o_rd1_en), .o_rd1_frame(o_rd1_frame), .o_rd1_addr(o_rd1_addr),
        .i_rd1_pixel(i_rd1_pixel), .i_rd1_depth(i_rd1_depth),
        .o_frame_start(o_frame_start), .o_f_or_d(o_f_or_d),
        .o_valid_0(o_valid_0), .o_data0(o_data0), .o_depth0(o_depth0),
        .o_valid_1(o_valid_1), .o_data1(o_data1), .o_depth1(o_depth1),
        .i_feature_ready(i_feature_ready), .i_done(i_done), .i_pose(i_pose),
        .i_sigma_icp_next(i_sigma_icp_next), .i_sigma_rgbd_next(i_sigma_rgbd_next),
        .o_pose(o_pose), .o_sigma_icp(o_sigma_icp), .o_sigma_rgbd(o_sigma_rgbd),
        .o_err_done(o_err_done)
    );

    always #5 clk = ~clk;

    // Stored frame contents: distinct per frame and address.
    function automatic logic [7:0] gray(input logic [1:0] f, input logic [18:0] a);
        return {f, 6'd0} + a[7:0];
    endfunction
    function automatic logic [15:0] depth(input logic [1:0] f, input logic [18:0] a);
        return 16'h1000 * (16'(f) + 16'd1) + 16'(a) * 16'd7;
    endfunction

    // Memory with 1-cycle read latency; junk when not strobed.
    always @(posedge clk) begin
        i_rd0_pixel <= o_rd0_en ? gray(o_rd0_frame, o_rd0_addr) : 8'hEE;
        i_rd0_depth <= o_rd0_en ? depth(o_rd0_frame, o_rd0_addr) : 16'hDEAD;
        i_rd1_pixel <= o_rd1_en ? gray(o_rd1_frame, o_rd1_addr) : 8'hEE;
        i_rd1_depth <= o_rd1_en ? depth(o_rd1_frame, o_rd1_addr) : 16'hDEAD;
    end

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] depth;
        logic        start;
    } beat_t;

    beat_t q0[$], q1[$];
    int    total = 0, bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int f, input int port, input bit start);
        beat_t e;
        for (int a = 0; a < NPIX; a++) begin
            e.data  = gray(2'(f), 19'(a));
            e.depth = depth(2'(f), 19'(a));
            e.start = start && (a == 0);
            if (port == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (q0.size() == 0 && q1.size() == 0), 1);
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            0: i_go = 1'b1;
            1: i_feature_ready = 1'b1;
            default: i_done = 1'b1;
        endcase
        @(posedge clk); #1;
        i_go = 1'b0; i_feature_ready = 1'b0; i_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},    o_busy, 0);
        check({tag, "_alldone"}, o_all_done, 0);
        check({tag, "_err"},     o_err_done, 0);
        check({tag, "_ford"},    o_f_or_d, 0);
        check({tag, "_rd_en"},   {o_rd0_en, o_rd1_en}, 0);
        check({tag, "_addr"},    {o_rd0_addr, o_rd1_addr}, 0);
        check({tag, "_valid"},   {o_valid_0, o_valid_1, o_frame_start}, 0);
        check({tag, "_data"},    {o_data0, o_depth0, o_data1, o_depth1}, 0);
        check({tag, "_pose0"},   o_pose[0], ONE);
        check({tag, "_pose5"},   o_pose[5], ONE);
        check({tag, "_pose10"},  o_pose[10], ONE);
        check({tag, "_pose3"},   o_pose[3], 0);
        check({tag, "_s_icp"},   o_sigma_icp, ICP_INIT);
        check({tag, "_s_rgbd"},  o_sigma_rgbd, RGBD_INIT);
    endtask

    // Scoreboard monitor.
    beat_t e0, e1;
    bit    exp_start;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_start = 1'b0;
            if (o_valid_0) begin
                if (q0.size() == 0) check("s0_unexpected_beat", 1, 0);
                else begin
                    e0 = q0.pop_front();
                    check("s0_data", o_data0, e0.data);
                    check("s0_depth", o_depth0, e0.depth);
                    exp_start |= e0.start;
                end
            end
            if (o_valid_1) begin
                if (q1.size() == 0) check("s1_unexpected_beat", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    check("s1_data", o_data1, e1.data);
                    check("s1_depth", o_depth1, e1.depth);
                    exp_start |= e1.start;
                end
            end
            if (o_valid_0 || o_valid_1 || o_frame_start)
                check("frame_start", o_frame_start, exp_start);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int run, gap;
        bit seen, found;
        rst_n = 1'b0; i_go = 1'b0; i_feature_ready = 1'b0; i_done = 1'b0;
        i_pose = '0; i_sigma_icp_next = '0; i_sigma_rgbd_next = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // ---- feature frame 0 ----
        push_frame(0, 0, 1);
        @(posedge clk); #1 i_go = 1'b1;
        @(posedge clk); #1 i_go = 1'b0;
        @(negedge clk);
        check("go_strobe", {o_rd0_en, o_rd0_addr, o_valid_0, o_busy}, {1'b1, 19'd0, 1'b0, 1'b1});
        @(negedge clk);
        check("go_first_beat", {o_valid_0, o_frame_start}, 2'b11);
        run = 1;
        for (int i = 1; i < NPIX; i++) begin
            @(negedge clk);
            if (o_valid_0) run++;
        end
        check("feat0_contiguous", run, NPIX);
        @(negedge clk);
        check("feat0_end", o_valid_0, 0);

        // ---- feature wait: no strobes without ready ----
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_rd0_en || o_valid_0) seen = 1'b1;
        end
        check("feat_wait_idle", seen, 0);

        // ---- feature frame 1, with a stray i_done while streaming ----
        push_frame(1, 0, 1);
        pulse(1);
        repeat (3) @(posedge clk);
        #1 i_done = 1'b1;
        @(posedge clk); #1 i_done = 1'b0;
        @(negedge clk);
        check("err_in_feat_str", o_err_done, 1);
        check("feat1_streaming", {o_rd0_en, o_rd0_frame, o_f_or_d}, {1'b1, 2'd1, 1'b0});
        check("feat1_pose_kept", o_pose[3], 0);
        wait_drain(100, "feat1_drain");
        repeat (2) @(negedge clk);
        check("done_wait_quiet", {o_busy, o_rd0_en}, 2'b10);

        // ---- first solve: pose only, direct phase starts ----
        for (int k = 0; k < 12; k++) i_pose[k] = PBW'(k * 1000);
        i_pose[3] = 42'd100;
        i_sigma_icp_next = 84'hABC;
        i_sigma_rgbd_next = 9'd7;
        push_frame(1, 1, 1);
        push_frame(0, 0, 0);
        pulse(2);
        @(negedge clk);
        check("dir0_pose3", o_pose[3], 100);
        check("dir0_pose0", o_pose[0], 0);
        check("dir0_ford", o_f_or_d, 1);
        check("dir0_sig_icp_kept", o_sigma_icp, ICP_INIT);
        check("dir0_sig_rgbd_kept", o_sigma_rgbd, RGBD_INIT);
        check("dir0_port1_start", {o_rd1_en, o_rd1_frame, o_rd1_addr, o_rd0_en},
              {1'b1, 2'd1, 19'd0, 1'b0});
        found = 1'b0; gap = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clk);
            if (o_rd0_en) begin found = 1'b1; gap = c; end
        end
        check("s0_delay", gap, 5);
        wait_drain(200, "dir0_drain");
        repeat (2) @(negedge clk);

        // ---- direct iteration 1 -> 2 ----
        i_pose[3] = 42'd200;
        i_sigma_icp_next = 84'h1_2345_6789;
        i_sigma_rgbd_next = 9'd7;
        push_frame(1, 1, 1);
        push_frame(0, 0, 0);
        pulse(2);
        @(negedge clk);
        check("dir1_sig_rgbd", o_sigma_rgbd, 7);
        check("dir1_sig_icp", o_sigma_icp, 84'h1_2345_6789);
        check("dir1_pose3", o_pose[3], 200);
        check("dir1_restart", {o_rd1_en, o_rd1_addr}, {1'b1, 19'd0});
        wait_drain(200, "dir1_drain");
        repeat (2) @(negedge clk);

        // ---- last solve -> FINISH ----
        i_pose[3] = 42'd300;
        i_sigma_icp_next = 84'h55;
        i_sigma_rgbd_next = 9'd9;
        pulse(2);
        @(negedge clk);
        check("finish_pulse", {o_all_done, o_busy}, 2'b11);
        check("finish_sig_rgbd", o_sigma_rgbd, 9);
        @(negedge clk);
        check("finish_after", {o_all_done, o_busy, o_f_or_d}, 3'b000);
        check("finish_retain", {o_pose[3], o_sigma_icp}, {42'd300, 84'h55});

        // ---- second run, reset in the middle of the direct phase ----
        push_frame(0, 0, 1);
        pulse(0);
        wait_drain(100, "run2_f0_drain");
        push_frame(1, 0, 1);
        pulse(1);
        wait_drain(100, "run2_f1_drain");
        repeat (2) @(negedge clk);
        push_frame(1, 1, 1);
        push_frame(0, 0, 0);
        pulse(2);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check_reset_vals("midrun");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {o_busy, o_rd0_en, o_rd1_en}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
